// File: rtl/snn_lif_array.sv
// snn_lif_array: array of leaky integrate-and-fire neurons.
//
// Each accepted timestep (active && in_valid) integrates one input current
// per channel into an unsigned membrane state. A channel fires when the
// saturated sum reaches the threshold. After firing, the channel is held
// at 0 for a programmable number of refractory timesteps.
//
// Ports:
//   wb_clk_i     system clock
//   reset        asynchronous, active-high reset
//   active       enable; when low, neurons hold and outputs idle
//   in_valid     one-cycle strobe: apply in_data as one timestep
//   in_data      per-channel input current, channel i at [i*IN_W +: IN_W]
//   cfg_we       config write strobe
//   cfg_addr     0 threshold, 1 leak_shift, 2 refr_len, 3 mode / count clear
//   cfg_data     config write data
//   spike_out    registered per-channel spike pulse
//   state_out    registered membrane state, channel i at [i*STATE_W +: STATE_W]
//   spike_count  total spikes across all channels, saturating
//   out_valid    high one cycle after each accepted timestep
module snn_lif_array #(
    parameter int N_NEURONS      = 4,
    parameter int IN_W           = 8,
    parameter int STATE_W        = 8,
    parameter int THRESH_DEFAULT = 128,
    parameter int CNT_W          = 16
) (
    input  logic                           wb_clk_i,
    input  logic                           reset,
    input  logic                           active,
    input  logic                           in_valid,
    input  logic [N_NEURONS*IN_W-1:0]      in_data,
    input  logic                           cfg_we,
    input  logic [1:0]                     cfg_addr,
    input  logic [31:0]                    cfg_data,
    output logic [N_NEURONS-1:0]           spike_out,
    output logic [N_NEURONS*STATE_W-1:0]   state_out,
    output logic [CNT_W-1:0]               spike_count,
    output logic                           out_valid
);

    localparam int POP_W = $clog2(N_NEURONS + 1);

    logic [STATE_W-1:0]   thresh_q;
    logic [2:0]           leak_shift_q;
    logic [3:0]           refr_len_q;
    logic                 mode_q;

    logic [STATE_W-1:0]   state_q [N_NEURONS];
    logic [STATE_W-1:0]   state_d [N_NEURONS];
    logic [3:0]           refr_q  [N_NEURONS];
    logic [3:0]           refr_d  [N_NEURONS];
    logic [N_NEURONS-1:0] spike_q, spike_d;
    logic                 valid_q;
    logic [CNT_W-1:0]     count_q, count_d;

    logic [STATE_W-1:0]   leak_v  [N_NEURONS];
    logic [STATE_W:0]     sum_w   [N_NEURONS];
    logic [STATE_W-1:0]   sum_s   [N_NEURONS];
    logic [POP_W-1:0]     pop;
    logic [CNT_W:0]       cnt_sum;

    logic                 step;
    logic                 cnt_clr;
    logic                 unused_cfg;

    assign step       = active && in_valid;
    assign cnt_clr    = cfg_we && (cfg_addr == 2'd3) && cfg_data[1];
    assign unused_cfg = ^cfg_data;

    // Per-channel integrate / fire / refractory logic.
    always_comb begin
        for (int i = 0; i < N_NEURONS; i++) begin
            // A shift of 0 means "no leak", not "leak everything".
            leak_v[i]  = (leak_shift_q == 3'd0) ? '0 : (state_q[i] >> leak_shift_q);
            // leak never exceeds state, so the subtraction cannot underflow.
            sum_w[i]   = {1'b0, state_q[i]} - {1'b0, leak_v[i]}
                         + (STATE_W+1)'(in_data[i*IN_W +: IN_W]);
            sum_s[i]   = sum_w[i][STATE_W] ? '1 : sum_w[i][STATE_W-1:0];
            state_d[i] = state_q[i];
            refr_d[i]  = refr_q[i];
            spike_d[i] = 1'b0;
            if (step) begin
                if (refr_q[i] != 4'd0) begin
                    refr_d[i]  = refr_q[i] - 4'd1;
                    state_d[i] = '0;
                end else if (sum_s[i] >= thresh_q) begin
                    spike_d[i] = 1'b1;
                    state_d[i] = mode_q ? (sum_s[i] - thresh_q) : '0;
                    refr_d[i]  = refr_len_q;
                end else begin
                    state_d[i] = sum_s[i];
                end
            end
        end
    end

    // Saturating spike counter; a clear in the same cycle discards that
    // cycle's spikes.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            pop = pop + POP_W'(spike_d[i]);
        end
        cnt_sum = {1'b0, count_q} + (CNT_W+1)'(pop);
        if (cnt_clr) begin
            count_d = '0;
        end else if (cnt_sum[CNT_W]) begin
            count_d = '1;
        end else begin
            count_d = cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge wb_clk_i or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= '0;
                refr_q[i]  <= '0;
            end
            spike_q      <= '0;
            valid_q      <= 1'b0;
            count_q      <= '0;
            thresh_q     <= STATE_W'(THRESH_DEFAULT);
            leak_shift_q <= '0;
            refr_len_q   <= '0;
            mode_q       <= 1'b0;
        end else begin
            for (int i = 0; i < N_NEURONS; i++) begin
                state_q[i] <= state_d[i];
                refr_q[i]  <= refr_d[i];
            end
            spike_q <= spike_d;
            valid_q <= step;
            count_q <= count_d;
            // Config registers update on the same edge as the timestep, so
            // the timestep in flight still sees the old values.
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: thresh_q     <= cfg_data[STATE_W-1:0];
                    2'd1: leak_shift_q <= cfg_data[2:0];
                    2'd2: refr_len_q   <= cfg_data[3:0];
                    2'd3: mode_q       <= cfg_data[0];
                endcase
            end
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            state_out[i*STATE_W +: STATE_W] = state_q[i];
        end
    end

    assign spike_out   = spike_q;
    assign out_valid   = valid_q;
    assign spike_count = count_q;

endmodule

// File: tb/tb_snn_lif_array.sv
module tb_snn_lif_array;

    localparam int N  = 4;
    localparam int IW = 8;
    localparam int SW = 8;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            active, in_valid, cfg_we;
    logic [N*IW-1:0] in_data;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_data;
    logic [N-1:0]    spike_out;
    logic [N*SW-1:0] state_out;
    logic [CW-1:0]   spike_count;
    logic            out_valid;

    snn_lif_array #(
        .N_NEURONS(N), .IN_W(IW), .STATE_W(SW), .THRESH_DEFAULT(128), .CNT_W(CW)
    ) dut (
        .wb_clk_i(clk), .reset(rst), .active(active), .in_valid(in_valid),
        .in_data(in_data), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .spike_out(spike_out), .state_out(state_out), .spike_count(spike_count),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers following the neuron rules.
    int m_st [N];
    int m_rf [N];
    int m_thr, m_ls, m_rl, m_md, m_cnt, m_spk, m_vld;

    int tests = 0;
    int fails = 0;

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0;
            m_rf[i] = 0;
        end
        m_thr = 128; m_ls = 0; m_rl = 0; m_md = 0;
        m_cnt = 0; m_spk = 0; m_vld = 0;
    endfunction

    function automatic void model_step(bit a, bit v, logic [N*IW-1:0] d,
                                       bit we, logic [1:0] ad, logic [31:0] cd);
        int spikes = 0;
        m_spk = 0;
        m_vld = 0;
        if (a && v) begin
            m_vld = 1;
            for (int i = 0; i < N; i++) begin
                int in_i, leak, sum;
                in_i = int'((d >> (i*IW)) & 32'hff);
                if (m_rf[i] > 0) begin
                    m_rf[i] = m_rf[i] - 1;
                    m_st[i] = 0;
                end else begin
                    leak = (m_ls == 0) ? 0 : m_st[i] / (1 << m_ls);
                    sum  = m_st[i] - leak + in_i;
                    if (sum > 255) sum = 255;
                    if (sum >= m_thr) begin
                        m_spk   = m_spk | (1 << i);
                        spikes  = spikes + 1;
                        m_st[i] = m_md ? sum - m_thr : 0;
                        m_rf[i] = m_rl;
                    end else begin
                        m_st[i] = sum;
                    end
                end
            end
        end
        if (we) begin
            case (ad)
                2'd0: m_thr = int'(cd & 32'hff);
                2'd1: m_ls  = int'(cd & 32'h7);
                2'd2: m_rl  = int'(cd & 32'hf);
                2'd3: m_md  = int'(cd & 32'h1);
            endcase
        end
        if (we && ad == 2'd3 && cd[1]) m_cnt = 0;
        else begin
            m_cnt = m_cnt + spikes;
            if (m_cnt > 65535) m_cnt = 65535;
        end
    endfunction

    function automatic int ch_state(int i);
        return int'((state_out >> (i*SW)) & 32'hff);
    endfunction

    task automatic check_all(string tag);
        check({tag, " spike_out"}, spike_out, m_spk);
        check({tag, " out_valid"}, out_valid, m_vld);
        check({tag, " spike_count"}, spike_count, m_cnt);
        for (int i = 0; i < N; i++)
            check($sformatf("%s state ch%0d", tag, i), ch_state(i), m_st[i]);
    endtask

    task automatic idle_inputs();
        active = 1'b1; in_valid = 1'b0; in_data = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    task automatic cyc(string tag, bit a, bit v, logic [N*IW-1:0] d,
                       bit we, logic [1:0] ad, logic [31:0] cd);
        @(negedge clk);
        active = a; in_valid = v; in_data = d;
        cfg_we = we; cfg_addr = ad; cfg_data = cd;
        @(posedge clk);
        model_step(a, v, d, we, ad, cd);
        #1;
        check_all(tag);
    endtask

    task automatic cfg(logic [1:0] ad, logic [31:0] cd);
        cyc("cfg", 1'b1, 1'b0, '0, 1'b1, ad, cd);
    endtask

    task automatic step(string tag, logic [N*IW-1:0] d);
        cyc(tag, 1'b1, 1'b1, d, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          a;
        bit          v;
        logic [31:0] d;
        bit          we;
        logic [1:0]  ad;
        logic [31:0] cd;
        logic [3:0]  exp_spk;
        logic [31:0] exp_state;
        int          exp_cnt;
        bit          exp_vld;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Threshold 100, ch0 = 30 per step, then active-low and config edge cases.
        tbl.push_back('{1, 0, 32'd0,  1, 2'd0, 32'd100, 4'b0000, 32'h00, 0, 0});
        tbl.push_back('{1, 1, 32'd30, 0, 2'd0, 32'd0,   4'b0000, 32'h1e, 0, 1});
        tbl.push_back('{1, 1, 32'd30, 0, 2'd0, 32'd0,   4'b0000, 32'h3c, 0, 1});
        tbl.push_back('{1, 1, 32'd30, 0, 2'd0, 32'd0,   4'b0000, 32'h5a, 0, 1});
        tbl.push_back('{1, 1, 32'd30, 0, 2'd0, 32'd0,   4'b0001, 32'h00, 1, 1});
        tbl.push_back('{1, 0, 32'd0,  0, 2'd0, 32'd0,   4'b0000, 32'h00, 1, 0});
        tbl.push_back('{0, 1, 32'd30, 0, 2'd0, 32'd0,   4'b0000, 32'h00, 1, 0});
        tbl.push_back('{0, 1, 32'd50, 1, 2'd0, 32'd20,  4'b0000, 32'h00, 1, 0});
        tbl.push_back('{1, 1, 32'd30, 0, 2'd0, 32'd0,   4'b0001, 32'h00, 2, 1});
        tbl.push_back('{1, 1, 32'd15, 1, 2'd0, 32'd10,  4'b0000, 32'h0f, 2, 1});
        tbl.push_back('{1, 1, 32'd0,  0, 2'd0, 32'd0,   4'b0001, 32'h00, 3, 1});
        tbl.push_back('{0, 1, 32'd99, 0, 2'd0, 32'd0,   4'b0000, 32'h00, 3, 0});

        idle_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        check_all("por");
        do_reset();

        for (int k = 0; k < tbl.size(); k++) begin
            string t;
            t = $sformatf("tbl%0d", k);
            cyc(t, tbl[k].a, tbl[k].v, tbl[k].d, tbl[k].we, tbl[k].ad, tbl[k].cd);
            check({t, " exp spike"}, spike_out, tbl[k].exp_spk);
            check({t, " exp state"}, state_out, tbl[k].exp_state);
            check({t, " exp count"}, spike_count, tbl[k].exp_cnt);
            check({t, " exp valid"}, out_valid, tbl[k].exp_vld);
        end

        // mode=1: residual after firing.
        do_reset();
        cfg(2'd0, 32'd100);
        cfg(2'd3, 32'd1);
        for (int k = 0; k < 4; k++) step("mode1", 32'd30);
        check("mode1 residual", ch_state(0), 20);
        check("mode1 spike", spike_out, 4'b0001);
        for (int k = 0; k < 10; k++) step("mode1 run", 32'd30);

        // Leak with shift 1 from a preloaded 100.
        do_reset();
        cfg(2'd0, 32'd255);
        step("leak preload", 32'd100 << 8);
        cfg(2'd1, 32'd1);
        begin
            int exp_leak[4] = '{50, 25, 13, 7};
            for (int k = 0; k < 4; k++) begin
                step("leak", 32'd0);
                check($sformatf("leak step%0d ch1", k), ch_state(1), exp_leak[k]);
                check($sformatf("leak step%0d spike", k), spike_out, 4'b0000);
            end
        end

        // Saturation at the top of the state range.
        do_reset();
        cfg(2'd0, 32'd255);
        step("sat a", 32'd250 << 16);
        step("sat b", 32'd20 << 16);
        check("sat spike", spike_out, 4'b0100);
        check("sat state", ch_state(2), 0);
        check("sat count", spike_count, 1);

        // Refractory period of 2.
        do_reset();
        cfg(2'd0, 32'd50);
        cfg(2'd2, 32'd2);
        begin
            logic [3:0] exp_r[4] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000};
            for (int k = 0; k < 4; k++) begin
                step("refr", 32'd60 << 24);
                check($sformatf("refr step%0d spike", k), spike_out, exp_r[k]);
                check($sformatf("refr step%0d ch3", k), ch_state(3), 0);
            end
        end

        // Count clear colliding with a two-channel spike.
        do_reset();
        cfg(2'd0, 32'd10);
        step("clr pre", 32'h0000_1414);
        check("clr pre count", spike_count, 2);
        cyc("clr hit", 1'b1, 1'b1, 32'h0000_1414, 1'b1, 2'd3, 32'd2);
        check("clr hit spike", spike_out, 4'b0011);
        check("clr hit count", spike_count, 0);

        // Asynchronous reset in the middle of a run.
        cfg(2'd0, 32'd40);
        step("mid a", 32'h0a14_1e28);
        step("mid b", 32'h0a14_1e28);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async rst");
        @(negedge clk);
        rst = 1'b0;
        step("post rst a", 32'd127);
        check("post rst no spike", spike_out, 4'b0000);
        step("post rst b", 32'd1);
        check("post rst thr128", spike_out, 4'b0001);

        // Randomised traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            bit          a, v, we;
            logic [1:0]  ad;
            logic [31:0] cd;
            a  = ($urandom % 8) != 0;
            v  = ($urandom % 4) != 0;
            we = ($urandom % 6) == 0;
            ad = 2'($urandom % 4);
            case (ad)
                2'd0: cd = $urandom_range(0, 255);
                2'd1: cd = $urandom_range(0, 7);
                2'd2: cd = $urandom_range(0, 3);
                default: cd = $urandom_range(0, 3);
            endcase
            cyc("rand", a, v, $urandom, we, ad, cd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/snn_lif_array.md
Name: snn_lif_array

Overview:
- Parametrised array of leaky integrate-and-fire (LIF) neurons.
- Successor to the fixed single-configuration SNN core. Adds a configurable neuron count, configurable widths, a runtime-programmable threshold, leak and refractory period, selectable reset mode, and a saturating spike counter.
- Sits under the user wrapper. Input currents and config come from logic-analyzer/IO lanes; spikes and membrane state are driven back to IO/LA.

Parameters:
- N_NEURONS, 4, number of neuron channels (1..16)
- IN_W, 8, unsigned input current width per channel
- STATE_W, 8, unsigned membrane state width (STATE_W >= IN_W)
- THRESH_DEFAULT, 128, threshold value after reset
- CNT_W, 16, spike counter width

Ports:
- wb_clk_i  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- active  input  1  enable; when low, no neuron updates occur
- in_valid  input  1  one-cycle strobe: apply in_data as one timestep
- in_data  input  N_NEURONS*IN_W  per-channel input current, channel i at [i*IN_W +: IN_W]
- cfg_we  input  1  config write strobe
- cfg_addr  input  2  config register select
- cfg_data  input  32  config write data
- spike_out  output  N_NEURONS  registered per-channel spike pulse
- state_out  output  N_NEURONS*STATE_W  registered membrane state
- spike_count  output  CNT_W  total spikes across all channels, saturating
- out_valid  output  1  high one cycle after each accepted timestep

Behaviour:
- Reset (async, immediate):
  - all state = 0, all refractory counters = 0
  - spike_out = 0, out_valid = 0, spike_count = 0
  - threshold = THRESH_DEFAULT, leak_shift = 0, refr_len = 0, mode = 0
- Config registers, written on a cfg_we clock edge:
  - addr0: threshold = cfg_data[STATE_W-1:0]
  - addr1: leak_shift = cfg_data[2:0]
  - addr2: refr_len = cfg_data[3:0]
  - addr3: mode = cfg_data[0]; cfg_data[1]=1 clears spike_count (self-clearing pulse, not stored)
- Config timing: a write in the same cycle as a timestep takes effect from the next timestep; the timestep uses the old values.
- A timestep is accepted when active && in_valid. Per channel i, with refr_i the channel's refractory counter:
  - If refr_i > 0: refr_i decrements, state stays 0, input is ignored, no spike.
  - Otherwise:
    - leak = (leak_shift == 0) ? 0 : state >> leak_shift
    - sum = state - leak + in_i, computed at STATE_W+1 bits, then saturated to 2^STATE_W-1
    - if sum >= threshold: spike_i = 1; new state = 0 when mode=0, sum - threshold when mode=1; refr_i = refr_len
    - else: spike_i = 0; new state = sum
- Threshold 0 makes every non-refractory channel spike each timestep.
- Latency: spike_out, state_out and out_valid update on the edge that accepts the timestep, so they are visible one cycle after in_valid.
- spike_out and out_valid are single-cycle pulses; they return to 0 on any non-accepting cycle.
- spike_count += popcount(spikes) per timestep, saturating at 2^CNT_W-1, no wrap.
- Clear and spikes in the same cycle: clear wins, count = 0, and that cycle's spikes are not counted.
- active low: in_valid is ignored, state and refractory counters hold, spike_out and out_valid are 0. Config writes are still accepted.
- Reset asserted mid-timestep: all registers clear asynchronously; the first timestep after deassertion integrates from 0.

Test Plan:
- N=4, threshold=100, leak_shift=0, mode=0; in_data ch0=30, others 0, 4 timesteps -> ch0 state 30,60,90 then spike_out=4'b0001, state 0, spike_count=1.
- Same stimulus, mode=1 -> 4th timestep spikes with residual state 20; ch0=30 per step -> spikes every 3–4 steps; count matches spikes seen.
- leak_shift=1, threshold=255, preload ch1 to 100, then in=0 x4 -> states 50,25,13,7 (100-50=50, 50-25=25, 25-12=13, 13-6=7); no spike.
- threshold=255, ch2 state 250 + in 20 -> saturates to 255, spikes, state 0; spike_count increments by 1.
- refr_len=2, threshold=50, ch3 in=60 every step -> spike at step1, steps 2–3 state 0 with no spike, spike again at step4.
- Boundaries:
  - cfg addr3 clear in the same cycle as a 2-channel spike -> spike_count=0.
  - active=0 with in_valid pulses -> no change.
  - reset mid-run -> all outputs 0 and threshold back to 128.
